// File: rtl/rat_pkg.sv
// Shared types for the RAT flag stage: flag pair struct and load-source encodings.
package rat_pkg;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  localparam logic LD_SRC_ALU  = 1'b0;
  localparam logic LD_SRC_SHAD = 1'b1;

endpackage

// File: rtl/int_sync_edge.sv
// Synchronizes an asynchronous line through SYNC_STAGES flops (legal 2..4)
// and emits a one-cycle pulse on each synchronized rising edge.
module int_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe <= '0;
      hist      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], din};
      hist      <= sync_pipe[SYNC_STAGES-1];
    end
  end

  assign rise = sync_pipe[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/rat_flag_unit.sv
// RAT flag register stage: C/Z flags with shadow save/restore, interrupt enable,
// and the synchronized, edge-detected interrupt pending latch.
module rat_flag_unit
  import rat_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic C_IN,
  input  logic Z_IN,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_LD_SEL,
  input  logic FLG_SHAD_LD,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INT_IN,
  input  logic INT_ACK,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic INT_PEND,
  output logic INT_REQ
);

  flags_t flg, shad, src;
  logic   i_flg, pend, rise;

  always_comb begin
    src = shad;
    if (FLG_LD_SEL == LD_SRC_ALU) begin
      src.c = C_IN;
      src.z = Z_IN;
    end
  end

  // Shadow captures pre-edge flags, so a save+restore in one edge swaps them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flg  <= '0;
      shad <= '0;
    end else begin
      if (FLG_C_CLR)      flg.c <= 1'b0;
      else if (FLG_C_SET) flg.c <= 1'b1;
      else if (FLG_C_LD)  flg.c <= src.c;
      if (FLG_Z_LD)       flg.z <= src.z;
      if (FLG_SHAD_LD)    shad  <= flg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)        i_flg <= 1'b0;
    else if (I_CLR) i_flg <= 1'b0;
    else if (I_SET) i_flg <= 1'b1;
  end

  int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (INT_IN),
    .rise (rise)
  );

  // A fresh edge beats a same-cycle acknowledge so no event is lost.
  always_ff @(posedge CLK) begin
    if (RST)          pend <= 1'b0;
    else if (rise)    pend <= 1'b1;
    else if (INT_ACK) pend <= 1'b0;
  end

  assign C_FLAG   = flg.c;
  assign Z_FLAG   = flg.z;
  assign I_FLAG   = i_flg;
  assign INT_PEND = pend;
  assign INT_REQ  = i_flg & pend;

endmodule

// File: tb/tb_rat_flag_unit.sv
// Directed scenarios plus random stimulus against a trace-based reference model.
module tb_rat_flag_unit;
  localparam int S = 2;

  logic CLK = 1'b0;
  logic RST, C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_LD_SEL;
  logic FLG_SHAD_LD, I_SET, I_CLR, INT_IN, INT_ACK;
  logic C_FLAG, Z_FLAG, I_FLAG, INT_PEND, INT_REQ;

  always #5 CLK = ~CLK;

  rat_flag_unit #(.SYNC_STAGES(S)) dut (
    .CLK(CLK), .RST(RST), .C_IN(C_IN), .Z_IN(Z_IN),
    .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .FLG_C_SET(FLG_C_SET),
    .FLG_C_CLR(FLG_C_CLR), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
    .I_SET(I_SET), .I_CLR(I_CLR), .INT_IN(INT_IN), .INT_ACK(INT_ACK),
    .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
    .INT_PEND(INT_PEND), .INT_REQ(INT_REQ)
  );

  int n_cmp = 0, n_err = 0;

  // Reference state: architectural flags, shadow, I, pending, and the full
  // trace of INT_IN values seen at each edge (edge index == trace index).
  logic mc = 0, mz = 0, msc = 0, msz = 0, mi = 0, mp = 0;
  logic trace[$];
  int   ecnt = 0, last_rst = -1;

  task automatic chk(string tag, logic obs, logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line value sampled at edge i; anything at or before the last reset is gone.
  function automatic logic smp(int i);
    if (i < 0 || i <= last_rst) return 1'b0;
    return trace[i];
  endfunction

  task automatic idle();
    RST = 0; FLG_C_LD = 0; FLG_Z_LD = 0; FLG_C_SET = 0; FLG_C_CLR = 0;
    FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
  endtask

  task automatic cyc();
    logic rise, sc, sz, nc, nz;
    @(posedge CLK);
    trace.push_back(INT_IN);
    if (RST) begin
      mc = 0; mz = 0; msc = 0; msz = 0; mi = 0; mp = 0;
      last_rst = ecnt;
    end else begin
      // INT_IN first seen high at edge k raises pending at edge k+S.
      rise = smp(ecnt - S) & ~smp(ecnt - S - 1);
      sc = FLG_LD_SEL ? msc : C_IN;
      sz = FLG_LD_SEL ? msz : Z_IN;
      nc = FLG_C_CLR ? 1'b0 : FLG_C_SET ? 1'b1 : FLG_C_LD ? sc : mc;
      nz = FLG_Z_LD ? sz : mz;
      if (FLG_SHAD_LD) begin msc = mc; msz = mz; end
      mc = nc; mz = nz;
      mi = I_CLR ? 1'b0 : I_SET ? 1'b1 : mi;
      mp = rise ? 1'b1 : INT_ACK ? 1'b0 : mp;
    end
    ecnt++;
    @(negedge CLK);
    chk("C", C_FLAG, mc);
    chk("Z", Z_FLAG, mz);
    chk("I", I_FLAG, mi);
    chk("PEND", INT_PEND, mp);
    chk("REQ", INT_REQ, mi & mp);
  endtask

  task automatic alu_load(logic c, logic z);
    idle(); C_IN = c; Z_IN = z; FLG_C_LD = 1; FLG_Z_LD = 1; cyc(); idle();
  endtask

  initial begin
    idle(); C_IN = 0; Z_IN = 0; INT_IN = 0;
    // Reset then idle
    RST = 1; cyc(); cyc(); idle();
    for (int i = 0; i < 10; i++) cyc();
    chk("rst_c", C_FLAG, 1'b0); chk("rst_z", Z_FLAG, 1'b0);
    chk("rst_i", I_FLAG, 1'b0); chk("rst_req", INT_REQ, 1'b0);

    // ALU load, then CLR beats SET
    alu_load(1, 0);
    chk("alu_c", C_FLAG, 1'b1); chk("alu_z", Z_FLAG, 1'b0);
    FLG_C_SET = 1; FLG_C_CLR = 1; cyc(); idle();
    chk("clr_wins", C_FLAG, 1'b0);

    // Save / restore
    alu_load(1, 1);
    FLG_SHAD_LD = 1; cyc(); idle();
    alu_load(0, 0);
    chk("cleared_c", C_FLAG, 1'b0); chk("cleared_z", Z_FLAG, 1'b0);
    FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 1; cyc(); idle();
    chk("restore_c", C_FLAG, 1'b1); chk("restore_z", Z_FLAG, 1'b1);

    // Swap: flags C=0,Z=1 with shadow C=1,Z=0
    alu_load(1, 0);
    FLG_SHAD_LD = 1; cyc(); idle();
    alu_load(0, 1);
    FLG_SHAD_LD = 1; FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 1; cyc(); idle();
    chk("swap_c", C_FLAG, 1'b1); chk("swap_z", Z_FLAG, 1'b0);
    FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 1; cyc(); idle();
    chk("swap_shad_c", C_FLAG, 1'b0); chk("swap_shad_z", Z_FLAG, 1'b1);

    // Interrupt latency, gating, single event from a held level
    INT_IN = 1; cyc();
    chk("lat_k", INT_PEND, 1'b0);
    cyc(); chk("lat_k1", INT_PEND, 1'b0);
    cyc(); chk("lat_k2", INT_PEND, 1'b1); chk("gated", INT_REQ, 1'b0);
    for (int i = 0; i < 17; i++) cyc();
    I_SET = 1; cyc(); idle();
    chk("req_on", INT_REQ, 1'b1);
    INT_ACK = 1; cyc(); idle();
    chk("ack_pend", INT_PEND, 1'b0); chk("ack_req", INT_REQ, 1'b0);
    for (int i = 0; i < 5; i++) cyc();
    chk("one_event", INT_PEND, 1'b0);

    // Edge coincident with acknowledge, then reset mid-pending
    INT_IN = 0; for (int i = 0; i < 4; i++) cyc();
    INT_IN = 1; cyc(); cyc(); cyc();
    chk("pend_again", INT_PEND, 1'b1);
    INT_IN = 0; for (int i = 0; i < 4; i++) cyc();
    INT_IN = 1; cyc(); cyc();
    INT_ACK = 1; cyc(); idle();
    chk("edge_wins", INT_PEND, 1'b1);
    RST = 1; cyc(); idle();
    chk("rst_pend", INT_PEND, 1'b0); chk("rst_i2", I_FLAG, 1'b0);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      RST         = ($urandom_range(63) == 0);
      C_IN        = 1'($urandom);
      Z_IN        = 1'($urandom);
      FLG_C_LD    = ($urandom_range(3) == 0);
      FLG_Z_LD    = ($urandom_range(3) == 0);
      FLG_C_SET   = ($urandom_range(7) == 0);
      FLG_C_CLR   = ($urandom_range(7) == 0);
      FLG_LD_SEL  = 1'($urandom);
      FLG_SHAD_LD = ($urandom_range(3) == 0);
      I_SET       = ($urandom_range(7) == 0);
      I_CLR       = ($urandom_range(9) == 0);
      INT_ACK     = ($urandom_range(5) == 0);
      if ($urandom_range(7) == 0) INT_IN = ~INT_IN;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
